fet_align: RTL and testbench
============================

FET_ALIGN -- requirements
Module: fet_align

Interface
- REQ-001: Parameter RESET_PC, default 32'h0000_0000; fetch_pc value after reset.
- REQ-002: clk  in  1  pipeline clock; all state updates on rising edge.
- REQ-003: cpurst  in  1  reset, asynchronous, active-high.
- REQ-004: fet_stall  in  1  downstream fetch/decode register holding; no instruction consumed this cycle.
- REQ-005: redirect  in  1  flush and redirect; taken branch, jump, exception or branch_predict_err.
- REQ-006: redirect_pc  in  32  new fetch pc; bit0 always 0.
- REQ-007: isram_rdata  in  32  instruction SRAM read word.
- REQ-008: isram_rvalid  in  1  isram_rdata valid; always exactly 1 cycle after an accepted isram_cs.
- REQ-009: isram_cs  out  1  SRAM read request.
- REQ-010: isram_addr  out  32  word address of request; bits[1:0] always 0.
- REQ-011: fetch_pc  out  32  pc of the instruction currently presented.
- REQ-012: rv32_instr_todec  out  32  presented instruction; {hw1,hw0} when 32-bit, {16'b0,hw0} when 16-bit.
- REQ-013: rv16_instr_todec  out  16  hw0 of the buffer.
- REQ-014: fe2de_rv16  out  1  presented instruction is compressed (hw0[1:0]!=2'b11).
- REQ-015: fetch_valid  out  1  a complete instruction is presented.
- REQ-016: cross_bd_ff  out  1  registered flag: last consumed instruction was 32-bit with pc[1]=1.

Function
- REQ-017: Halfword buffer: 4 x 16-bit entries hw0..hw3, count hcnt 0..4; hw0 oldest.
- REQ-018: fetch_valid = (hcnt>=1 & hw0[1:0]!=2'b11) | (hcnt>=2 & hw0[1:0]==2'b11); fetch_valid=0 in the redirect cycle.
- REQ-019: Consume when fetch_valid & ~fet_stall & ~redirect: shift out 1 halfword (rv16) or 2 halfwords (rv32); fetch_pc += 2 or 4.
- REQ-020: Request issue: isram_cs = ~outstanding & hcnt<=2 & ~redirect & ~cpurst; isram_addr = faddr; faddr += 4 on issue.
- REQ-021: outstanding set on issue and cleared when isram_rvalid arrives; max one request in flight.
- REQ-022: On isram_rvalid (no redirect): append rdata[15:0] then rdata[31:16] after the post-consume contents, hcnt += 2; if skip_lo=1, append rdata[31:16] only, hcnt += 1, and clear skip_lo.
- REQ-023: Consume and append in the same cycle: shift first, then append; hcnt never exceeds 4.
- REQ-024: Redirect has priority over consume, append and issue: hcnt<=0; fetch_pc<=redirect_pc; faddr<={redirect_pc[31:2],2'b00}; skip_lo<=redirect_pc[1]; a response arriving in the redirect cycle is discarded; outstanding cleared.
- REQ-025: Redirect latency: redirect at cycle R -> isram_cs at R+1 -> rvalid at R+2 -> fetch_valid at R+3 (aligned, or rv16 at pc[1]=1); 32-bit at pc[1]=1 -> second request at R+3, fetch_valid at R+5.
- REQ-026: cross_bd_ff <= 1 on consuming a 32-bit instruction with fetch_pc[1]=1; <= 0 on any other consume or on redirect; held otherwise.
- REQ-027: Outputs are driven with buffer contents even when fetch_valid=0; downstream qualifies with fetch_valid.

Reset
- REQ-028: cpurst=1 asynchronously forces hcnt=0, outstanding=0, skip_lo=0, cross_bd_ff=0, fetch_pc=RESET_PC, faddr=RESET_PC&~3; isram_cs=0 while cpurst=1.
- REQ-029: Reset mid-request: in-flight response is discarded; first request issues the cycle after cpurst deasserts.

Verification
- REQ-030: Reset release, SRAM word 0 = 32'h0000_0013 -> isram_cs at cycle 1 with addr 0; fetch_valid at cycle 3, fe2de_rv16=0, rv32_instr_todec=32'h0000_0013, fetch_pc=0.
- REQ-031: Word 0 = {16'h0001,16'h4501} (two rv16) -> consecutive consumes fetch_pc 0 then 2, rv16_instr_todec 16'h4501 then 16'h0001.
- REQ-032: Redirect to 32'h0000_0102, word 0x100 = {16'h0513,16'hxxxx}, word 0x104 = {16'hxxxx,16'h0000} -> fetch_valid at R+5, rv32_instr_todec=32'h0000_0513, after consume cross_bd_ff=1.
- REQ-033: fet_stall held 5 cycles with buffer full -> isram_cs=0, fetch_pc and outputs unchanged, hcnt stays 4.
- REQ-034: Redirect asserted in the same cycle as isram_rvalid and a consume -> response dropped, hcnt=0, fetch_pc=redirect_pc, no fetch_valid until R+3.
- REQ-035: cpurst pulsed while outstanding=1 -> response ignored, fetch_pc=RESET_PC, fresh request after release.

Source files
------------

// File: rtl/fet_align.sv
// rtl/fet_align.sv - halfword-aligning instruction fetch buffer between instruction SRAM and decode
module fet_align #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        cpurst,
  input  logic        fet_stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic [31:0] isram_rdata,
  input  logic        isram_rvalid,
  output logic        isram_cs,
  output logic [31:0] isram_addr,
  output logic [31:0] fetch_pc,
  output logic [31:0] rv32_instr_todec,
  output logic [15:0] rv16_instr_todec,
  output logic        fe2de_rv16,
  output logic        fetch_valid,
  output logic        cross_bd_ff
);

  // hw[0] is the oldest halfword; hcnt counts valid entries (0..4)
  logic [15:0] hw [4];
  logic [15:0] hn [4];
  logic [2:0]  hcnt;
  logic [2:0]  cnt_s;
  logic [2:0]  cnt_n;
  logic [31:0] faddr;
  logic        outstanding;
  logic        skip_lo;
  logic        is32;
  logic        consume;
  logic        resp;

  assign is32        = (hw[0][1:0] == 2'b11);
  assign fetch_valid = ~redirect & (((hcnt >= 3'd1) & ~is32) | ((hcnt >= 3'd2) & is32));
  assign consume     = fetch_valid & ~fet_stall;
  // a response only counts while its request is still live; stale ones after reset/redirect are dropped
  assign resp        = isram_rvalid & outstanding;

  assign isram_cs         = ~outstanding & (hcnt <= 3'd2) & ~redirect & ~cpurst;
  assign isram_addr       = faddr;
  assign rv16_instr_todec = hw[0];
  assign fe2de_rv16       = ~is32;
  assign rv32_instr_todec = is32 ? {hw[1], hw[0]} : {16'h0000, hw[0]};

  // next buffer contents: shift out the consumed instruction, then append the response behind what remains
  always_comb begin
    hn    = hw;
    cnt_s = hcnt;
    if (consume) begin
      if (is32) begin
        hn[0] = hw[2];
        hn[1] = hw[3];
        cnt_s = hcnt - 3'd2;
      end else begin
        hn[0] = hw[1];
        hn[1] = hw[2];
        hn[2] = hw[3];
        cnt_s = hcnt - 3'd1;
      end
    end
    cnt_n = cnt_s;
    if (resp) begin
      if (skip_lo) begin
        // fetch started at pc[1]=1: the low halfword of the first word precedes the target
        for (int i = 0; i < 4; i++) begin
          if (3'(i) == cnt_s) hn[i] = isram_rdata[31:16];
        end
        cnt_n = cnt_s + 3'd1;
      end else begin
        for (int i = 0; i < 4; i++) begin
          if (3'(i) == cnt_s)        hn[i] = isram_rdata[15:0];
          if (3'(i) == cnt_s + 3'd1) hn[i] = isram_rdata[31:16];
        end
        cnt_n = cnt_s + 3'd2;
      end
    end
  end

  // state update: reset, then redirect flush, then normal consume/append/issue
  always_ff @(posedge clk or posedge cpurst) begin
    if (cpurst) begin
      hw          <= '{default: 16'h0000};
      hcnt        <= 3'd0;
      outstanding <= 1'b0;
      skip_lo     <= 1'b0;
      cross_bd_ff <= 1'b0;
      fetch_pc    <= RESET_PC;
      faddr       <= RESET_PC & ~32'h3;
    end else if (redirect) begin
      hcnt        <= 3'd0;
      outstanding <= 1'b0;
      skip_lo     <= redirect_pc[1];
      cross_bd_ff <= 1'b0;
      fetch_pc    <= redirect_pc;
      faddr       <= {redirect_pc[31:2], 2'b00};
    end else begin
      hw   <= hn;
      hcnt <= cnt_n;
      if (consume) begin
        fetch_pc    <= fetch_pc + (is32 ? 32'd4 : 32'd2);
        cross_bd_ff <= is32 & fetch_pc[1];
      end
      if (isram_cs) begin
        outstanding <= 1'b1;
        faddr       <= faddr + 32'd4;
      end else if (resp) begin
        outstanding <= 1'b0;
      end
      if (resp) skip_lo <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fet_align.sv
// tb/tb_fet_align.sv - randomized and directed self-checking bench for fet_align
module tb_fet_align;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk;
  logic        cpurst;
  logic        fet_stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] isram_rdata;
  logic        isram_rvalid;
  logic        isram_cs;
  logic [31:0] isram_addr;
  logic [31:0] fetch_pc;
  logic [31:0] rv32_instr_todec;
  logic [15:0] rv16_instr_todec;
  logic        fe2de_rv16;
  logic        fetch_valid;
  logic        cross_bd_ff;

  fet_align #(.RESET_PC(RST_PC)) dut (
    .clk              (clk),
    .cpurst           (cpurst),
    .fet_stall        (fet_stall),
    .redirect         (redirect),
    .redirect_pc      (redirect_pc),
    .isram_rdata      (isram_rdata),
    .isram_rvalid     (isram_rvalid),
    .isram_cs         (isram_cs),
    .isram_addr       (isram_addr),
    .fetch_pc         (fetch_pc),
    .rv32_instr_todec (rv32_instr_todec),
    .rv16_instr_todec (rv16_instr_todec),
    .fe2de_rv16       (fe2de_rv16),
    .fetch_valid      (fetch_valid),
    .cross_bd_ff      (cross_bd_ff)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // instruction memory: explicit overrides, otherwise a fixed hash of the address
  logic [31:0] ovr [logic [31:0]];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    logic [31:0] h;
    if (ovr.exists(a)) return ovr[a];
    h = a * 32'h9E37_79B1;
    h = h ^ (h >> 15);
    h = h * 32'h85EB_CA6B;
    h = h ^ (h >> 13);
    return h;
  endfunction

  function automatic logic [15:0] hw_at(input logic [31:0] pc);
    logic [31:0] w;
    w = mem_rd(pc & ~32'h3);
    return pc[1] ? w[31:16] : w[15:0];
  endfunction

  // reference model: halfword queue plus fetch bookkeeping
  logic [15:0] hq[$];
  logic [31:0] m_pc;
  logic [31:0] m_faddr;
  logic        m_out;
  logic        m_skip;
  logic        m_cross;

  // SRAM environment: answers exactly one cycle after an accepted request
  logic        pend;
  logic [31:0] pend_addr;

  // snapshots of the last sampled cycle, for directed checks
  logic        s_valid;
  logic        s_cs;
  logic        s_rv16;
  logic [31:0] s_addr;
  logic [31:0] s_pc;
  logic [31:0] s_i32;
  logic [15:0] s_i16;
  logic        s_cross;

  task automatic cyc(input logic r, input logic st, input logic rd, input logic [31:0] rp);
    logic        ev;
    logic        ecs;
    logic        q32;
    logic [15:0] h0;
    logic [31:0] e32;
    logic [31:0] rdat;
    int          n;
    cpurst       = r;
    fet_stall    = st;
    redirect     = rd;
    redirect_pc  = rp;
    isram_rvalid = pend;
    rdat         = pend ? mem_rd(pend_addr) : 32'hDEAD_BEEF;
    isram_rdata  = rdat;
    #1;
    if (r) begin
      hq.delete();
      m_pc    = RST_PC;
      m_faddr = RST_PC & ~32'h3;
      m_out   = 1'b0;
      m_skip  = 1'b0;
      m_cross = 1'b0;
    end
    n   = hq.size();
    q32 = (n >= 1) ? (hq[0][1:0] == 2'b11) : 1'b0;
    ev  = !r && !rd && (n >= 1) && (!q32 || n >= 2);
    ecs = !r && !m_out && (n <= 2) && !rd;
    chk("fetch_valid", 32'(fetch_valid), 32'(ev));
    chk("isram_cs", 32'(isram_cs), 32'(ecs));
    chk("fetch_pc", fetch_pc, m_pc);
    chk("cross_bd_ff", 32'(cross_bd_ff), 32'(m_cross));
    if (ecs) chk("isram_addr", isram_addr, m_faddr);
    if (ev) begin
      h0  = hw_at(m_pc);
      e32 = (h0[1:0] == 2'b11) ? {hw_at(m_pc + 32'd2), h0} : {16'h0000, h0};
      chk("rv32_instr", rv32_instr_todec, e32);
      chk("rv16_instr", 32'(rv16_instr_todec), 32'(h0));
      chk("fe2de_rv16", 32'(fe2de_rv16), 32'(h0[1:0] != 2'b11));
    end
    s_valid = fetch_valid; s_cs = isram_cs; s_addr = isram_addr; s_pc = fetch_pc;
    s_i32 = rv32_instr_todec; s_i16 = rv16_instr_todec; s_rv16 = fe2de_rv16; s_cross = cross_bd_ff;
    if (!r) begin
      if (rd) begin
        hq.delete();
        m_pc    = rp;
        m_faddr = {rp[31:2], 2'b00};
        m_skip  = rp[1];
        m_out   = 1'b0;
        m_cross = 1'b0;
      end else begin
        if (ev && !st) begin
          m_cross = q32 && m_pc[1];
          void'(hq.pop_front());
          if (q32) void'(hq.pop_front());
          m_pc = m_pc + (q32 ? 32'd4 : 32'd2);
        end
        if (pend && m_out) begin
          if (!m_skip) hq.push_back(rdat[15:0]);
          hq.push_back(rdat[31:16]);
          m_skip = 1'b0;
          m_out  = 1'b0;
        end
        if (ecs) begin
          m_out   = 1'b1;
          m_faddr = m_faddr + 32'd4;
        end
      end
    end
    pend      = isram_cs;
    pend_addr = isram_addr;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] sv_pc;
  logic [31:0] sv_i32;

  initial begin
    pend = 1'b0; pend_addr = 32'h0;
    cpurst = 1'b1; fet_stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    isram_rvalid = 1'b0; isram_rdata = 32'h0;
    @(posedge clk);
    #1;

    // reset release, aligned 32-bit word at 0
    ovr[32'h0] = 32'h0000_0013;
    cyc(1, 0, 0, 0);
    chk("rst_pc", s_pc, RST_PC);
    chk("rst_cs", 32'(s_cs), 32'h0);
    chk("rst_valid", 32'(s_valid), 32'h0);
    cyc(0, 1, 0, 0);
    chk("c1_cs", 32'(s_cs), 32'h1);
    chk("c1_addr", s_addr, 32'h0);
    cyc(0, 1, 0, 0);
    chk("c2_valid", 32'(s_valid), 32'h0);
    cyc(0, 0, 0, 0);
    chk("c3_valid", 32'(s_valid), 32'h1);
    chk("c3_rv16", 32'(s_rv16), 32'h0);
    chk("c3_i32", s_i32, 32'h0000_0013);
    chk("c3_pc", s_pc, 32'h0);

    // two compressed instructions in word 0
    cyc(1, 0, 0, 0);
    ovr[32'h0] = {16'h0001, 16'h4501};
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("rv16a_pc", s_pc, 32'h0);
    chk("rv16a_i16", 32'(s_i16), 32'h4501);
    cyc(0, 0, 0, 0);
    chk("rv16b_valid", 32'(s_valid), 32'h1);
    chk("rv16b_pc", s_pc, 32'h2);
    chk("rv16b_i16", 32'(s_i16), 32'h0001);

    // redirect to a 32-bit instruction straddling a word boundary
    ovr[32'h100] = {16'h0513, 16'hBEEF};
    ovr[32'h104] = {16'hAAAA, 16'h0000};
    cyc(0, 1, 1, 32'h102);
    for (int k = 1; k <= 4; k++) begin
      cyc(0, 0, 0, 0);
      chk("straddle_wait", 32'(s_valid), 32'h0);
    end
    cyc(0, 0, 0, 0);
    chk("straddle_valid", 32'(s_valid), 32'h1);
    chk("straddle_i32", s_i32, 32'h0000_0513);
    cyc(0, 1, 0, 0);
    chk("straddle_cross", 32'(s_cross), 32'h1);
    chk("straddle_pc", s_pc, 32'h106);

    // stall until full, then hold for 5 cycles
    for (int k = 0; k < 8; k++) cyc(0, 1, 0, 0);
    sv_pc  = s_pc;
    sv_i32 = s_i32;
    for (int k = 0; k < 5; k++) begin
      cyc(0, 1, 0, 0);
      chk("full_cs", 32'(s_cs), 32'h0);
      chk("full_pc", s_pc, sv_pc);
      chk("full_i32", s_i32, sv_i32);
    end

    // redirect colliding with a response and a consume
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 32'h200);
    chk("coll_rvalid", 32'(isram_rvalid), 32'h1);
    chk("coll_valid", 32'(s_valid), 32'h0);
    cyc(0, 0, 0, 0);
    chk("coll_pc", s_pc, 32'h200);
    chk("coll_r1_valid", 32'(s_valid), 32'h0);
    cyc(0, 0, 0, 0);
    chk("coll_r2_valid", 32'(s_valid), 32'h0);
    cyc(0, 0, 0, 0);
    chk("coll_r3_valid", 32'(s_valid), 32'h1);

    // reset pulse while a request is in flight
    cyc(0, 1, 1, 32'h300);
    cyc(0, 1, 0, 0);
    chk("inflight_cs", 32'(s_cs), 32'h1);
    cyc(1, 1, 0, 0);
    chk("pulse_pc", s_pc, RST_PC);
    cyc(0, 1, 0, 0);
    chk("fresh_cs", 32'(s_cs), 32'h1);
    chk("fresh_addr", s_addr, RST_PC & ~32'h3);
    cyc(0, 1, 0, 0);
    chk("fresh_wait", 32'(s_valid), 32'h0);

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      logic r;
      logic st;
      logic rd;
      logic [31:0] rp;
      r  = ($urandom_range(0, 199) == 0);
      st = ($urandom_range(0, 9) < 3);
      rd = ($urandom_range(0, 19) == 0);
      rp = 32'($urandom_range(0, 1023)) & ~32'h1;
      cyc(r, st, rd, rp);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
